mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: consumes the EX/MEM register outputs and drives the data-memory bus.

---
 rtl/mem_stage_lsu.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit issuing one req/gnt/rvalid transaction per load or store.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of silently aligning them.
module mem_stage_lsu #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        StallM,
   output logic [31:0] ReadDataM,
   output logic        BusErrM,
   output logic        MisalignM
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [31:0] rdata_q, rdata_d;
   logic        buserr_q, buserr_d;
   logic        misalign_q, misalign_d;
   logic        is_store, is_load, access, misalign, timeout_hit, req;
   logic [1:0]  size;
   logic [3:0]  be_raw;
   logic [31:0] wd_raw, load_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign is_store = MemWriteM;
   assign is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
   assign access   = is_store | is_load;
   assign size     = Funct3M[1:0];

`ifdef MISALIGN_TRAP_EN
   assign misalign = access & (((size == 2'b01) & ALUResultM[0]) |
                               (size[1] & (ALUResultM[1:0] != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   // Saturating so that TIMEOUT=0 never wraps back to a spurious match.
   assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      be_raw = 4'b1111;
      wd_raw = WriteDataM;
      case (size)
         2'b00: begin
            be_raw = 4'b0001 << ALUResultM[1:0];
            wd_raw = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be_raw = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wd_raw = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign byte_v = mem_rdata[{ALUResultM[1:0], 3'b000} +: 8];
   assign half_v = mem_rdata[{ALUResultM[1], 4'b0000} +: 16];

   always_comb begin
      load_ext = mem_rdata;
      case (size)
         2'b00:   load_ext = Funct3M[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   load_ext = Funct3M[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      buserr_d   = 1'b0;
      misalign_d = 1'b0;
      req        = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (misalign) begin
                  state_d    = DONE;
                  misalign_d = 1'b1;
                  rdata_d    = 32'h0;
               end else begin
                  req     = 1'b1;
                  cnt_d   = '0;
                  state_d = mem_gnt ? (is_store ? DONE : WAIT) : REQ;
               end
            end
         end
         REQ: begin
            req = 1'b1;
            if (mem_gnt) begin
               state_d = is_store ? DONE : WAIT;
               cnt_d   = '0;
            end else if (timeout_hit) begin
               state_d  = DONE;
               buserr_d = 1'b1;
               rdata_d  = 32'h0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d = DONE;
               rdata_d = load_ext;
            end else if (timeout_hit) begin
               state_d  = DONE;
               buserr_d = 1'b1;
               rdata_d  = 32'h0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rdata_q    <= 32'h0;
         buserr_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         buserr_q   <= buserr_d;
         misalign_q <= misalign_d;
      end
   end

   // Gated by rst_n so nothing reaches the bus or the pipeline while reset is held.
   assign mem_req   = req & rst_n;
   assign mem_we    = mem_req & is_store;
   assign mem_addr  = mem_req ? {ALUResultM[31:2], 2'b00} : 32'h0;
   assign mem_be    = mem_req ? be_raw : 4'h0;
   assign mem_wdata = (mem_req & is_store) ? wd_raw : 32'h0;

   assign StallM    = rst_n & access & (state_q != DONE);
   assign ReadDataM = rdata_q;
   assign BusErrM   = buserr_q;
   assign MisalignM = misalign_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scripted bus responder plus expected-result queue for mem_stage_lsu (TIMEOUT=8).
// Build with or without MISALIGN_TRAP_EN; expectations follow the same macro.
module tb_mem_stage_lsu;
   localparam int TO    = 8;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        BusErrM, MisalignM;

   // {check_rdata, stall_cycles[7:0], buserr, misalign, rdata[31:0]}
   logic [42:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   mem_stage_lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .StallM(StallM), .ReadDataM(ReadDataM),
      .BusErrM(BusErrM), .MisalignM(MisalignM)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not reach its summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
      return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*a[1:0] +: 8];
      h = rd[16*a[1] +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   task automatic exp_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input bit st, output logic [3:0] be, output logic [31:0] wdo);
      be  = 4'b0000;
      wdo = 32'h0;
      case (f3[1:0])
         2'b00: begin
            be[a[1:0]] = 1'b1;
            wdo = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         end
         2'b01: begin
            be  = a[1] ? 4'b1100 : 4'b0011;
            wdo = {wd[15:0], wd[15:0]};
         end
         default: begin
            be  = 4'b1111;
            wdo = wd;
         end
      endcase
      if (!st) wdo = 32'h0;
   endtask

   // Called at posedge+1. g = cycles until gnt (0 = IDLE cycle), r = cycles from gnt to rvalid.
   task automatic run_access(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int g,
                             input int r, input logic [31:0] rd, input bit noise);
      logic [42:0] e;
      logic [3:0]  ebe;
      logic [31:0] ewd, erd;
      bit st, ld, mis, berr, done;
      int stall, k;
      st   = we;
      ld   = !we && rs == 2'b01;
      mis  = is_mis(f3, a);
      berr = 1'b0;
      erd  = 32'h0;
      if (mis) stall = 1;
      else if (g > TO) begin stall = 1 + TO; berr = 1'b1; end
      else if (st) stall = g + 1;
      else if (r > TO) begin stall = g + 1 + TO; berr = 1'b1; end
      else begin stall = g + r + 1; erd = exp_load(f3, a, rd); end
      e = {(ld || berr || mis), 8'(stall), berr, mis, erd};
      exp_q.push_back(e);
      exp_lanes(f3, a, wd, st, ebe, ewd);
      MemWriteM = we; ResultSrcM = rs; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
      done = 1'b0;
      k = 0;
      while (!done && k < 64) begin
         mem_gnt    = (k == g);
         mem_rvalid = (k == g + r) || (noise && (k <= g || k == g + r + 1));
         mem_rdata  = (k == g + r) ? rd : $urandom;
         @(negedge clk);
         check("mem_req", mem_req, !mis && k <= g && k < stall);
         if (mem_req) begin
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            check("mem_be", mem_be, ebe);
            check("mem_we", mem_we, st);
            check("mem_wdata", mem_wdata, ewd);
         end else begin
            check("bus_idle", {mem_we, mem_be, mem_addr, mem_wdata}, 64'h0);
         end
         if (!StallM) begin
            done = 1'b1;
            e = exp_q.pop_front();
            check("stall_cycles", k, e[41:34]);
            check("BusErrM", BusErrM, e[33]);
            check("MisalignM", MisalignM, e[32]);
            if (e[42]) check("ReadDataM", ReadDataM, e[31:0]);
         end else begin
            check("pulse_low", {BusErrM, MisalignM}, 2'b00);
         end
         @(posedge clk);
         #1;
         k++;
      end
      if (!done) begin
         check("done_timeout", 0, 1);
         void'(exp_q.pop_front());
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   logic [2:0] f3_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   initial begin
      rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
      ALUResultM = 32'h40; WriteDataM = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_StallM", StallM, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_ReadDataM", ReadDataM, 0);
      check("rst_pulses", {BusErrM, MisalignM}, 0);
      ResultSrcM = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Non-memory instructions never stall or touch the bus.
      for (int i = 0; i < 3; i++) begin
         MemWriteM = 1'b0; ResultSrcM = (i == 0) ? 2'b00 : 2'b10;
         mem_rvalid = (i == 2); mem_rdata = $urandom;
         @(negedge clk);
         check("pass_StallM", StallM, 0);
         check("pass_mem_req", mem_req, 0);
         @(posedge clk);
         #1;
      end
      mem_rvalid = 1'b0;

      run_access(1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0, 0);
      run_access(0, 2'b01, 3'b000, 32'h103, 0, 2, 1, 32'h80FF_FFFF, 0);
      run_access(0, 2'b01, 3'b100, 32'h103, 0, 2, 1, 32'h80FF_FFFF, 1);
      run_access(1, 2'b00, 3'b001, 32'h102, 32'h0000_1234, 0, 1, 0, 0);
      run_access(0, 2'b01, 3'b101, 32'h102, 0, 0, 1, 32'hABCD_0000, 0);

      // Reset while in WAIT: everything abandoned, late rvalid ignored.
      MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h200;
      mem_gnt = 1'b1;
      @(negedge clk);
      check("rw_req", mem_req, 1);
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      @(negedge clk);
      check("rw_wait_req", mem_req, 0);
      check("rw_wait_stall", StallM, 1);
      rst_n = 1'b0;
      #1;
      check("rw_StallM", StallM, 0);
      check("rw_mem_req", mem_req, 0);
      check("rw_ReadDataM", ReadDataM, 0);
      check("rw_BusErrM", BusErrM, 0);
      @(posedge clk);
      #1 ResultSrcM = 2'b00; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_1234;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rw_late_stall", StallM, 0);
      check("rw_late_req", mem_req, 0);
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
      @(negedge clk);
      check("rw_late_rdata", ReadDataM, 0);
      @(posedge clk);
      #1;

      run_access(0, 2'b01, 3'b010, 32'h300, 0, NEVER, 1, 0, 0);
      run_access(1, 2'b00, 3'b010, 32'h304, 32'h1111_2222, NEVER, 1, 0, 1);
      run_access(0, 2'b01, 3'b010, 32'h308, 0, 1, NEVER, 0, 0);
      run_access(0, 2'b01, 3'b010, 32'h30C, 0, TO, TO, 32'hCAFE_F00D, 0);
      run_access(0, 2'b01, 3'b010, 32'h101, 0, 0, 1, 32'h1122_3344, 0);
      run_access(1, 2'b01, 3'b000, 32'h101, 32'h0000_00A5, 1, 1, 0, 1);
      run_access(0, 2'b01, 3'b001, 32'h100, 0, 0, 2, 32'h0000_8001, 1);
      run_access(0, 2'b01, 3'b001, 32'h103, 0, 1, 1, 32'h7FFF_0000, 0);

      for (int i = 0; i < 24; i++) begin
         logic we;
         we = 1'($urandom_range(0, 1));
         run_access(we, we ? 2'($urandom_range(0, 3)) : 2'b01, f3_tab[$urandom_range(0, 4)],
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom, 1'($urandom_range(0, 1)));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
